sw_row_loader: RTL and testbench

- Upstream feeder for the motion-estimation datapath.
- Once per macro-search it fetches the 4x4 current (reference) block from the reference pixel memory and holds it stable.
- It then streams the 19 rows of the 19x19 search window, one 19-pixel row per cycle, into the 16 SAD arrays.
- Handshake is start/busy/done; memory reads use 1-cycle-latency synchronous ports.

---
 rtl/sw_row_loader.sv | 135 +++++++++++++
 tb/tb_sw_row_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_row_loader.sv
// Search-window row loader: fetches the 4x4 reference block once per search,
// then streams the window rows (one row per cycle) to the SAD arrays.
module sw_row_loader #(
  parameter int ADDR_W     = 11,
  parameter int WIN_ROWS   = 19,
  parameter int REF_ROWS   = 4,
  parameter int WIN_STRIDE = 1,
  parameter int REF_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] win_base,
  input  logic [ADDR_W-1:0] ref_base,
  output logic              busy,
  output logic              done,
  output logic              win_rd,
  output logic [ADDR_W-1:0] win_addr,
  input  logic [151:0]      win_rdata,
  output logic              ref_rd,
  output logic [ADDR_W-1:0] ref_addr,
  input  logic [31:0]       ref_rdata,
  output logic [151:0]      row_out,
  output logic              row_valid,
  output logic [4:0]        row_idx,
  output logic [127:0]      ref_out,
  output logic              ref_valid
);

  typedef enum logic [2:0] {IDLE, LOAD_REF, STREAM, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] WS = ADDR_W'(WIN_STRIDE);
  localparam logic [ADDR_W-1:0] RS = ADDR_W'(REF_STRIDE);

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   win_base_q, win_base_d;
  logic [ADDR_W-1:0]   ref_base_q, ref_base_d;
  logic                ref_lat_q, ref_lat_d;
  logic [4:0]          ref_lidx_q, ref_lidx_d;
  logic                win_lat_q, win_lat_d;
  logic [4:0]          row_idx_q, row_idx_d;
  logic [151:0]        row_hold_q, row_hold_d;
  logic [127:0]        ref_q, ref_d;
  logic                ref_valid_q, ref_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_base_q  <= '0;
      ref_base_q  <= '0;
      ref_lat_q   <= 1'b0;
      ref_lidx_q  <= '0;
      win_lat_q   <= 1'b0;
      row_idx_q   <= '0;
      row_hold_q  <= '0;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_base_q  <= win_base_d;
      ref_base_q  <= ref_base_d;
      ref_lat_q   <= ref_lat_d;
      ref_lidx_q  <= ref_lidx_d;
      win_lat_q   <= win_lat_d;
      row_idx_q   <= row_idx_d;
      row_hold_q  <= row_hold_d;
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_base_d  = win_base_q;
    ref_base_d  = ref_base_q;
    // Read data returns one cycle after the strobe; these flags track it.
    ref_lat_d   = (state_q == LOAD_REF);
    ref_lidx_d  = cnt_q;
    win_lat_d   = (state_q == STREAM);
    row_idx_d   = win_lat_d ? cnt_q : row_idx_q;
    row_hold_d  = win_lat_q ? win_rdata : row_hold_q;
    ref_d       = ref_q;
    ref_valid_d = ref_valid_q;

    for (int i = 0; i < REF_ROWS; i++)
      if (ref_lat_q && ref_lidx_q == 5'(i)) ref_d[32*i +: 32] = ref_rdata;
    if (ref_lat_q && ref_lidx_q == 5'(REF_ROWS-1)) ref_valid_d = 1'b1;

    case (state_q)
      IDLE: if (start) begin
        win_base_d  = win_base;
        ref_base_d  = ref_base;
        ref_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = LOAD_REF;
      end
      LOAD_REF: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(REF_ROWS-1)) begin
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIN_ROWS-1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign ref_rd   = (state_q == LOAD_REF);
  assign win_rd   = (state_q == STREAM);
  assign ref_addr = ref_rd ? ref_base_q + ADDR_W'(cnt_q) * RS : '0;
  assign win_addr = win_rd ? win_base_q + ADDR_W'(cnt_q) * WS : '0;

  // Row arrives from memory this cycle; forward it and keep a copy for holding.
  assign row_out   = win_lat_q ? win_rdata : row_hold_q;
  assign row_valid = win_lat_q;
  assign row_idx   = row_idx_q;
  assign ref_out   = ref_q;
  assign ref_valid = ref_valid_q;

endmodule

// File: tb/tb_sw_row_loader.sv
// Scoreboard bench for sw_row_loader: stimulus pushes cycle-tagged expected
// events, a negedge monitor pops and compares them.
module tb_sw_row_loader;

  localparam logic [127:0] EXP_REF = 128'h0f0e0d0c0b0a09080706050403020100;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [10:0]  win_base = '0, ref_base = '0;
  logic         busy, done, win_rd, ref_rd, row_valid, ref_valid;
  logic [10:0]  win_addr, ref_addr;
  logic [151:0] win_rdata = '0, row_out;
  logic [31:0]  ref_rdata = '0;
  logic [4:0]   row_idx;
  logic [127:0] ref_out;

  sw_row_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_base(win_base), .ref_base(ref_base),
    .busy(busy), .done(done), .win_rd(win_rd), .win_addr(win_addr), .win_rdata(win_rdata),
    .ref_rd(ref_rd), .ref_addr(ref_addr), .ref_rdata(ref_rdata), .row_out(row_out),
    .row_valid(row_valid), .row_idx(row_idx), .ref_out(ref_out), .ref_valid(ref_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct { int cyc; logic [156:0] val; } ev_t;
  ev_t q_ref[$], q_win[$], q_row[$], q_done[$];
  int  acc_q[$];

  logic [10:0] cur_wb = '0, cur_rb = '0, wd_off, rd_off;
  assign wd_off = win_addr - cur_wb;
  assign rd_off = ref_addr - cur_rb;

  function automatic logic [151:0] win_row(int r);
    logic [151:0] w;
    for (int k = 0; k < 19; k++) w[8*k +: 8] = 8'((r*19 + k) % 256);
    return w;
  endfunction

  function automatic logic [31:0] ref_row(int i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  // Memory model: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (ref_rd) ref_rdata <= ref_row(int'(rd_off));
    if (win_rd) win_rdata <= win_row(int'(wd_off));
  end

  task automatic push_search(input int t0, input logic [10:0] wb, input logic [10:0] rb);
    logic [10:0] a;
    acc_q.push_back(t0);
    for (int i = 0; i < 4; i++) begin
      a = rb + 11'(i);
      q_ref.push_back('{cyc: t0+1+i, val: 157'(a)});
    end
    for (int r = 0; r < 19; r++) begin
      a = wb + 11'(r);
      q_win.push_back('{cyc: t0+5+r, val: 157'(a)});
      q_row.push_back('{cyc: t0+6+r, val: {5'(r), win_row(r)}});
    end
    q_done.push_back('{cyc: t0+25, val: '0});
  endtask

  task automatic chk(input string nm, input bit act, input bit has, input int fc,
                     input logic [156:0] fv, input logic [156:0] av, output bit pop);
    pop = 1'b0;
    if (act) begin
      n_chk++;
      if (!has || fc != cyc) begin
        n_fail++;
        $display("FAIL %s unexpected at cycle %0d got %h", nm, cyc, av);
        if (has && fc < cyc) pop = 1'b1;
      end else begin
        pop = 1'b1;
        if (av !== fv) begin
          n_fail++;
          $display("FAIL %s at cycle %0d got %h exp %h", nm, cyc, av, fv);
        end
      end
    end else if (has && fc <= cyc) begin
      n_chk++; n_fail++; pop = 1'b1;
      $display("FAIL %s missing at cycle %0d exp %h", nm, fc, fv);
    end
  endtask

  bit p_r, p_w, p_v, p_d, eb, ez;
  always @(negedge clk) if (rst_n) begin
    chk("ref_rd", ref_rd, q_ref.size() > 0, (q_ref.size() > 0) ? q_ref[0].cyc : 0,
        (q_ref.size() > 0) ? q_ref[0].val : '0, 157'(ref_addr), p_r);
    if (p_r) void'(q_ref.pop_front());
    chk("win_rd", win_rd, q_win.size() > 0, (q_win.size() > 0) ? q_win[0].cyc : 0,
        (q_win.size() > 0) ? q_win[0].val : '0, 157'(win_addr), p_w);
    if (p_w) void'(q_win.pop_front());
    chk("row", row_valid, q_row.size() > 0, (q_row.size() > 0) ? q_row[0].cyc : 0,
        (q_row.size() > 0) ? q_row[0].val : '0, {row_idx, row_out}, p_v);
    if (p_v) void'(q_row.pop_front());
    chk("done", done, q_done.size() > 0, (q_done.size() > 0) ? q_done[0].cyc : 0,
        '0, '0, p_d);
    if (p_d) void'(q_done.pop_front());

    if (row_valid) begin
      n_chk++;
      if (!ref_valid || ref_out !== EXP_REF) begin
        n_fail++;
        $display("FAIL ref_stable cycle %0d got v=%b %h exp v=1 %h", cyc, ref_valid, ref_out, EXP_REF);
      end
      if (row_idx == 5'd18) begin
        n_chk++;
        if (row_out[7:0] !== 8'h56) begin
          n_fail++;
          $display("FAIL row18_px0 got %h exp 56", row_out[7:0]);
        end
      end
    end

    n_chk++;
    if (win_rd && ref_rd) begin
      n_fail++;
      $display("FAIL rd_overlap cycle %0d got win_rd=1 ref_rd=1 exp not both", cyc);
    end

    eb = 1'b0; ez = 1'b0;
    foreach (acc_q[i]) begin
      if (cyc >= acc_q[i] + 1 && cyc <= acc_q[i] + 25) eb = 1'b1;
      if (cyc >= acc_q[i] + 1 && cyc <= acc_q[i] + 5)  ez = 1'b1;
    end
    n_chk++;
    if (busy !== eb) begin
      n_fail++;
      $display("FAIL busy cycle %0d got %b exp %b", cyc, busy, eb);
    end
    if (ez) begin
      n_chk++;
      if (ref_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ref_valid_clear cycle %0d got %b exp 0", cyc, ref_valid);
      end
    end
  end

  task automatic check_zero(input string tag);
    n_chk++;
    if ({busy, done, win_rd, ref_rd, row_valid, ref_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl got %b exp 000000", tag, {busy, done, win_rd, ref_rd, row_valid, ref_valid});
    end
    n_chk++;
    if (win_addr !== '0 || ref_addr !== '0 || row_idx !== '0 || row_out !== '0 || ref_out !== '0) begin
      n_fail++;
      $display("FAIL %s_data got wa=%h ra=%h idx=%0d row=%h ref=%h exp all 0",
               tag, win_addr, ref_addr, row_idx, row_out, ref_out);
    end
  endtask

  task automatic begin_search(input logic [10:0] wb, input logic [10:0] rb, output int t0);
    win_base = wb; ref_base = rb; cur_wb = wb; cur_rb = rb;
    start = 1'b1;
    t0 = cyc;
    push_search(t0, wb, rb);
  endtask

  int t0;
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Basic search; bases scrambled while busy must not matter.
    @(negedge clk);
    begin_search(11'h100, 11'h010, t0);
    @(negedge clk); start = 1'b0; win_base = 11'h555; ref_base = 11'h2AA;
    repeat (26) @(negedge clk);

    // Address wrap on both buses, plus start pulses during the search.
    begin_search(11'h7F8, 11'h7FE, t0);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);

    // Start held: back-to-back searches with a one-cycle IDLE gap.
    begin_search(11'h040, 11'h030, t0);
    push_search(t0 + 26, 11'h040, 11'h030);
    repeat (27) @(negedge clk); start = 1'b0;
    repeat (26) @(negedge clk);

    // Reset mid-search, then a clean search.
    begin_search(11'h300, 11'h050, t0);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    q_ref.delete(); q_win.delete(); q_row.delete(); q_done.delete(); acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_search(11'h200, 11'h020, t0);
    @(negedge clk); start = 1'b0;
    repeat (29) @(negedge clk);

    n_chk++;
    if (q_ref.size() + q_win.size() + q_row.size() + q_done.size() != 0) begin
      n_fail++;
      $display("FAIL leftover got %0d pending events exp 0",
               q_ref.size() + q_win.size() + q_row.size() + q_done.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
